// File: rtl/led_seq_ctrl_pkg.sv
// Shared constants for the LED sequencer: CSR map, CTRL/STATUS bit positions,
// FSM state and PIO grant encodings.
package led_seq_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_DIRECT   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_PATTERN0 = 3'd4;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_MODE     = 1;
  localparam int CTRL_ONE_SHOT = 2;
  localparam int CTRL_LAST_LO  = 4;

  localparam int STAT_RUN       = 0;
  localparam int STAT_DIR_PEND  = 1;
  localparam int STAT_STEP_PEND = 2;
  localparam int STAT_IDX_LO    = 4;
  localparam int STAT_DIR_OVR   = 8;
  localparam int STAT_STEP_OVR  = 9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  typedef enum logic {
    GNT_DIR  = 1'b0,
    GNT_STEP = 1'b1
  } grant_e;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// CSR slave port plus the Avalon-MM write port toward the LED PIO.
// The slave modport is the sequencer's view; master is the CPU/PIO side.
interface led_seq_ctrl_if;
  logic [2:0]  csr_address;
  logic        csr_chipselect;
  logic        csr_write_n;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  modport slave (
    input  csr_address, csr_chipselect, csr_write_n, csr_writedata,
    output csr_readdata,
    output pio_address, pio_chipselect, pio_write_n, pio_writedata
  );

  modport master (
    output csr_address, csr_chipselect, csr_write_n, csr_writedata,
    input  csr_readdata,
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata
  );
endinterface

// File: rtl/led_seq_ctrl_tick.sv
// Step period down-counter: load sets it to load_val, en counts down, and tick
// fires combinationally in the cycle the count sits at 0 (auto-reload next edge).
module led_seq_tick #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tick = en && !load && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = tick ? load_val : cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer and round-robin writer of the PIO: CPU direct writes and a
// step engine share one port; grant-to-strobe is 1 cycle, strobes at least 2 apart.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int          LED_WIDTH    = 19,
  parameter int          PERIOD_WIDTH = 24,
  parameter int unsigned PERIOD_RESET = 999_999
) (
  input  logic          clk,
  input  logic          reset_n,
  led_seq_ctrl_if.slave bus
);

  state_e                  state_q, state_d;
  grant_e                  grant_q, grant_d, last_grant_q, last_grant_d, gnt;
  logic                    run_q, run_d, mode_q, mode_d, one_shot_q, one_shot_d;
  logic [1:0]              last_idx_q, last_idx_d, idx_q, idx_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [LED_WIDTH-1:0]    shadow_q, shadow_d, dir_dat_q, dir_dat_d, pio_dat_q, pio_dat_d;
  logic [LED_WIDTH-1:0]    pattern_q [4];
  logic [LED_WIDTH-1:0]    pattern_d [4];
  logic                    dir_pend_q, dir_pend_d, step_pend_q, step_pend_d;
  logic                    dir_ovr_q, dir_ovr_d, step_ovr_q, step_ovr_d;
  logic                    first_q, first_d, stop_q, stop_d;

  logic [31:0]          wdata;
  logic [LED_WIDTH-1:0] step_val;
  logic                 wr, wr_ctrl, wr_dir, wr_period, wr_status, wr_pat;
  logic                 run_rise, run_fall, tick, clr_dir, clr_step;
  logic                 unused_ok;

  assign wdata     = bus.csr_writedata;
  assign unused_ok = ^wdata;
  assign wr        = bus.csr_chipselect && !bus.csr_write_n;
  assign wr_ctrl   = wr && (bus.csr_address == ADDR_CTRL);
  assign wr_dir    = wr && (bus.csr_address == ADDR_DIRECT);
  assign wr_period = wr && (bus.csr_address == ADDR_PERIOD);
  assign wr_status = wr && (bus.csr_address == ADDR_STATUS);
  assign wr_pat    = wr && bus.csr_address[2];
  assign run_rise  = wr_ctrl && wdata[CTRL_RUN] && !run_q;
  assign run_fall  = wr_ctrl && !wdata[CTRL_RUN] && run_q;
  assign clr_dir   = (state_q == ST_ISSUE) && (grant_q == GNT_DIR);
  assign clr_step  = (state_q == ST_ISSUE) && (grant_q == GNT_STEP);

  led_seq_tick #(.WIDTH(PERIOD_WIDTH)) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (run_rise),
    .en       (run_q),
    .load_val (period_q),
    .tick     (tick)
  );

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    gnt = GNT_STEP;
    if (dir_pend_q && (!step_pend_q || last_grant_q == GNT_STEP)) gnt = GNT_DIR;
  end

  always_comb begin
    step_val = pattern_q[idx_q];
    if (mode_q) begin
      step_val = first_q ? pattern_q[0] : {shadow_q[LED_WIDTH-2:0], shadow_q[LED_WIDTH-1]};
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    run_d        = run_q;
    mode_d       = mode_q;
    one_shot_d   = one_shot_q;
    last_idx_d   = last_idx_q;
    idx_d        = idx_q;
    period_d     = period_q;
    shadow_d     = shadow_q;
    dir_dat_d    = dir_dat_q;
    pio_dat_d    = pio_dat_q;
    pattern_d    = pattern_q;
    dir_ovr_d    = dir_ovr_q;
    step_ovr_d   = step_ovr_q;
    first_d      = first_q;
    stop_d       = stop_q;

    // W1C first so a same-cycle overflow event still lands.
    if (wr_status && wdata[STAT_DIR_OVR])  dir_ovr_d  = 1'b0;
    if (wr_status && wdata[STAT_STEP_OVR]) step_ovr_d = 1'b0;

    dir_pend_d = dir_pend_q && !clr_dir;
    if (wr_dir) begin
      dir_dat_d  = wdata[LED_WIDTH-1:0];
      dir_pend_d = 1'b1;
      if (dir_pend_q && !clr_dir) dir_ovr_d = 1'b1;
    end

    step_pend_d = step_pend_q && !clr_step;
    if (tick) begin
      step_pend_d = 1'b1;
      if (step_pend_q && !clr_step) step_ovr_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (dir_pend_q || step_pend_q) begin
          state_d      = ST_ISSUE;
          grant_d      = gnt;
          last_grant_d = gnt;
          stop_d       = 1'b0;
          if (gnt == GNT_DIR) begin
            // Forward a DIRECT write landing this cycle so the newest value wins.
            pio_dat_d = dir_dat_d;
          end else begin
            pio_dat_d = step_val;
            first_d   = 1'b0;
            if (!mode_q) begin
              idx_d  = (idx_q == last_idx_q) ? 2'd0 : idx_q + 2'd1;
              stop_d = one_shot_q && (idx_q == last_idx_q);
            end
          end
        end
      end
      ST_ISSUE: begin
        state_d  = ST_IDLE;
        shadow_d = pio_dat_q;
        if (grant_q == GNT_STEP && stop_q) begin
          run_d       = 1'b0;
          step_pend_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_ctrl) begin
      run_d      = wdata[CTRL_RUN];
      mode_d     = wdata[CTRL_MODE];
      one_shot_d = wdata[CTRL_ONE_SHOT];
      last_idx_d = wdata[CTRL_LAST_LO +: 2];
    end
    if (run_rise) begin
      step_pend_d = 1'b1;
      idx_d       = 2'd0;
      first_d     = 1'b1;
    end
    if (run_fall) step_pend_d = 1'b0;
    if (wr_period) period_d = wdata[PERIOD_WIDTH-1:0];
    if (wr_pat) pattern_d[bus.csr_address[1:0]] = wdata[LED_WIDTH-1:0];
  end

  always_comb begin
    bus.csr_readdata = '0;
    case (bus.csr_address)
      ADDR_CTRL: begin
        bus.csr_readdata[CTRL_RUN]          = run_q;
        bus.csr_readdata[CTRL_MODE]         = mode_q;
        bus.csr_readdata[CTRL_ONE_SHOT]     = one_shot_q;
        bus.csr_readdata[CTRL_LAST_LO +: 2] = last_idx_q;
      end
      ADDR_DIRECT: bus.csr_readdata = 32'(shadow_q);
      ADDR_PERIOD: bus.csr_readdata = 32'(period_q);
      ADDR_STATUS: begin
        bus.csr_readdata[STAT_RUN]         = run_q;
        bus.csr_readdata[STAT_DIR_PEND]    = dir_pend_q;
        bus.csr_readdata[STAT_STEP_PEND]   = step_pend_q;
        bus.csr_readdata[STAT_IDX_LO +: 2] = idx_q;
        bus.csr_readdata[STAT_DIR_OVR]     = dir_ovr_q;
        bus.csr_readdata[STAT_STEP_OVR]    = step_ovr_q;
      end
      default: bus.csr_readdata = 32'(pattern_q[bus.csr_address[1:0]]);
    endcase
  end

  assign bus.pio_address    = 2'd0;
  assign bus.pio_chipselect = (state_q == ST_ISSUE);
  assign bus.pio_write_n    = (state_q != ST_ISSUE);
  assign bus.pio_writedata  = 32'(pio_dat_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_DIR;
      last_grant_q <= GNT_STEP;
      run_q        <= 1'b0;
      mode_q       <= 1'b0;
      one_shot_q   <= 1'b0;
      last_idx_q   <= 2'd0;
      idx_q        <= 2'd0;
      period_q     <= PERIOD_WIDTH'(PERIOD_RESET);
      shadow_q     <= '0;
      dir_dat_q    <= '0;
      pio_dat_q    <= '0;
      dir_pend_q   <= 1'b0;
      step_pend_q  <= 1'b0;
      dir_ovr_q    <= 1'b0;
      step_ovr_q   <= 1'b0;
      first_q      <= 1'b0;
      stop_q       <= 1'b0;
      for (int i = 0; i < 4; i++) pattern_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      run_q        <= run_d;
      mode_q       <= mode_d;
      one_shot_q   <= one_shot_d;
      last_idx_q   <= last_idx_d;
      idx_q        <= idx_d;
      period_q     <= period_d;
      shadow_q     <= shadow_d;
      dir_dat_q    <= dir_dat_d;
      pio_dat_q    <= pio_dat_d;
      dir_pend_q   <= dir_pend_d;
      step_pend_q  <= step_pend_d;
      dir_ovr_q    <= dir_ovr_d;
      step_ovr_q   <= step_ovr_d;
      first_q      <= first_d;
      stop_q       <= stop_d;
      for (int i = 0; i < 4; i++) pattern_q[i] <= pattern_d[i];
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: records every PIO strobe (cycle, data) and
// compares against hand-computed schedules.
module tb_led_seq_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int          strb_cyc [$];
  logic [31:0] strb_dat [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_seq_ctrl_if bus ();

  led_seq_ctrl #(
    .LED_WIDTH    (19),
    .PERIOD_WIDTH (24),
    .PERIOD_RESET (999_999)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // A strobe seen in the cycle after grant edge E is logged as cycle E.
  always @(negedge clk) begin
    if (reset_n && bus.pio_chipselect && !bus.pio_write_n) begin
      strb_cyc.push_back(cyc);
      strb_dat.push_back(bus.pio_writedata);
    end
  end

  task automatic do_reset();
    bus.csr_address    = 3'd0;
    bus.csr_chipselect = 1'b0;
    bus.csr_write_n    = 1'b1;
    bus.csr_writedata  = 32'd0;
    reset_n            = 1'b0;
    repeat (3) @(negedge clk);
    strb_cyc.delete();
    strb_dat.delete();
    reset_n = 1'b1;
  endtask

  // Write sampled at posedge number ed, no earlier than posedge number at.
  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d, input int at, output int ed);
    @(negedge clk);
    while (cyc < at - 1) @(negedge clk);
    bus.csr_address    = a;
    bus.csr_chipselect = 1'b1;
    bus.csr_write_n    = 1'b0;
    bus.csr_writedata  = d;
    ed = cyc + 1;
    @(posedge clk);
    #1;
    bus.csr_chipselect = 1'b0;
    bus.csr_write_n    = 1'b1;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.csr_address = a;
    #1 d = bus.csr_readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    bus.csr_chipselect = 1'b0;
    bus.csr_write_n    = 1'b1;
    #1;
    checks++; if (bus.pio_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", bus.pio_chipselect); end
    checks++; if (bus.pio_write_n !== 1'b1) begin errors++; $display("FAIL rst_wn: got %b want 1", bus.pio_write_n); end
    do_reset();
    #1;
    checks++; if (bus.pio_address !== 2'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.pio_address); end
    checks++; if (bus.pio_writedata !== 32'd0) begin errors++; $display("FAIL rst_data: got %h want 0", bus.pio_writedata); end
    csr_rd(3'd0, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", rd); end
    csr_rd(3'd2, rd);
    checks++; if (rd !== 32'd999_999) begin errors++; $display("FAIL rst_period: got %0d want 999999", rd); end
    csr_rd(3'd3, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_status: got %h want 0", rd); end
    csr_rd(3'd1, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_shadow: got %h want 0", rd); end
    csr_rd(3'd6, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_pattern2: got %h want 0", rd); end
  endtask

  task automatic test_direct();
    int w;
    logic [31:0] rd;
    do_reset();
    csr_wr(3'd1, 32'h5A5A5, 0, w);
    repeat (6) @(negedge clk);
    checks++;
    if (strb_cyc.size() !== 1) begin
      errors++; $display("FAIL direct_count: got %0d want 1", strb_cyc.size());
    end else begin
      checks++; if (strb_cyc[0] !== w + 1) begin errors++; $display("FAIL direct_time: got %0d want %0d", strb_cyc[0], w + 1); end
      checks++; if (strb_dat[0] !== 32'h5A5A5) begin errors++; $display("FAIL direct_data: got %h want 5a5a5", strb_dat[0]); end
    end
    csr_rd(3'd1, rd);
    checks++; if (rd !== 32'h5A5A5) begin errors++; $display("FAIL direct_shadow: got %h want 5a5a5", rd); end
  endtask

  task automatic setup_table();
    int w;
    do_reset();
    csr_wr(3'd2, 32'd9, 0, w);
    csr_wr(3'd4, 32'd1, 0, w);
    csr_wr(3'd5, 32'd2, 0, w);
    csr_wr(3'd6, 32'd4, 0, w);
    csr_wr(3'd7, 32'd8, 0, w);
  endtask

  task automatic test_table();
    int r;
    logic [31:0] exp_d [5] = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd1};
    setup_table();
    csr_wr(3'd0, 32'h31, 0, r);
    repeat (46) @(negedge clk);
    checks++;
    if (strb_cyc.size() !== 5) begin
      errors++; $display("FAIL table_count: got %0d want 5", strb_cyc.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (strb_cyc[k] !== r + 1 + 10 * k) begin errors++; $display("FAIL table_time%0d: got %0d want %0d", k, strb_cyc[k], r + 1 + 10 * k); end
        checks++; if (strb_dat[k] !== exp_d[k]) begin errors++; $display("FAIL table_data%0d: got %h want %h", k, strb_dat[k], exp_d[k]); end
      end
    end
  endtask

  task automatic test_one_shot();
    int r;
    logic [31:0] rd;
    logic [31:0] exp_d [4] = '{32'd1, 32'd2, 32'd4, 32'd8};
    setup_table();
    csr_wr(3'd0, 32'h35, 0, r);
    repeat (70) @(negedge clk);
    checks++;
    if (strb_cyc.size() !== 4) begin
      errors++; $display("FAIL oneshot_count: got %0d want 4", strb_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (strb_dat[k] !== exp_d[k]) begin errors++; $display("FAIL oneshot_data%0d: got %h want %h", k, strb_dat[k], exp_d[k]); end
      end
    end
    csr_rd(3'd3, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL oneshot_status: got %h want 0", rd); end
    csr_rd(3'd0, rd);
    checks++; if (rd !== 32'h34) begin errors++; $display("FAIL oneshot_ctrl: got %h want 34", rd); end
  endtask

  task automatic test_chase();
    int r, w;
    logic [31:0] exp_d [3] = '{32'h40000, 32'h00001, 32'h00002};
    do_reset();
    csr_wr(3'd2, 32'd4, 0, w);
    csr_wr(3'd4, 32'h40000, 0, w);
    csr_wr(3'd0, 32'h03, 0, r);
    repeat (14) @(negedge clk);
    checks++;
    if (strb_cyc.size() !== 3) begin
      errors++; $display("FAIL chase_count: got %0d want 3", strb_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (strb_dat[k] !== exp_d[k]) begin errors++; $display("FAIL chase_data%0d: got %h want %h", k, strb_dat[k], exp_d[k]); end
        checks++; if (strb_cyc[k] !== r + 1 + 5 * k) begin errors++; $display("FAIL chase_time%0d: got %0d want %0d", k, strb_cyc[k], r + 1 + 5 * k); end
      end
    end
  endtask

  task automatic test_tie();
    int r, w;
    int          exp_c [7];
    logic [31:0] exp_d [7] = '{32'd1, 32'h11111, 32'd2, 32'h22222, 32'd4, 32'h33333, 32'd8};
    setup_table();
    csr_wr(3'd0, 32'h31, 0, r);
    csr_wr(3'd1, 32'h11111, r + 10, w);
    csr_wr(3'd1, 32'h22222, r + 15, w);
    csr_wr(3'd1, 32'h33333, r + 20, w);
    exp_c = '{r + 1, r + 11, r + 13, r + 16, r + 21, r + 23, r + 31};
    while (cyc < r + 34) @(negedge clk);
    checks++;
    if (strb_cyc.size() !== 7) begin
      errors++; $display("FAIL tie_count: got %0d want 7", strb_cyc.size());
    end else begin
      for (int k = 0; k < 7; k++) begin
        checks++; if (strb_cyc[k] !== exp_c[k]) begin errors++; $display("FAIL tie_time%0d: got %0d want %0d", k, strb_cyc[k], exp_c[k]); end
        checks++; if (strb_dat[k] !== exp_d[k]) begin errors++; $display("FAIL tie_data%0d: got %h want %h", k, strb_dat[k], exp_d[k]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    logic [31:0] rd;
    do_reset();
    csr_wr(3'd1, 32'h1, 0, w1);
    csr_wr(3'd1, 32'h2, 0, w2);
    repeat (6) @(negedge clk);
    checks++;
    if (strb_cyc.size() !== 1) begin
      errors++; $display("FAIL b2b_count: got %0d want 1", strb_cyc.size());
    end else begin
      checks++; if (strb_dat[0] !== 32'h2) begin errors++; $display("FAIL b2b_data: got %h want 2", strb_dat[0]); end
      checks++; if (strb_cyc[0] !== w1 + 1) begin errors++; $display("FAIL b2b_time: got %0d want %0d", strb_cyc[0], w1 + 1); end
    end
    csr_rd(3'd3, rd);
    checks++; if (rd !== 32'h100) begin errors++; $display("FAIL b2b_ovr: got %h want 100", rd); end
    csr_wr(3'd3, 32'h100, 0, w1);
    csr_rd(3'd3, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL b2b_w1c: got %h want 0", rd); end
    csr_rd(3'd1, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL b2b_shadow: got %h want 2", rd); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_table();
    test_one_shot();
    test_chase();
    test_tie();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
